// File: rtl/fsm_change_payout.sv
// Change payout controller: accumulates change strobes into a pending balance
// and pays it out through a coin hopper as 2-unit and 1-unit coins.
module fsm_change_payout #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       chg_vld,
    input  logic [2:0] chg_amt,
    output logic       hop2_req,
    output logic       hop1_req,
    input  logic       hop_ack,
    output logic [3:0] pend,
    output logic       busy,
    output logic       ovf,
    output logic       fault
);

    typedef enum logic [2:0] {
        IDLE,
        REQ2,
        REQ1,
        REL,
        FAULT
    } state_t;

    localparam logic [7:0] ACK_LIMIT = 8'(ACK_TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic [3:0] pend_nxt;
    logic       ovf_nxt;
    logic [1:0] dec;
    logic       accept;
    logic [4:0] sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
            pend  <= 4'd0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pend  <= pend_nxt;
            ovf   <= ovf_nxt;
        end
    end

    // An ack on the limit cycle is checked first, so it beats the timeout.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dec       = 2'd0;
        case (state)
            IDLE: begin
                if (pend >= 4'd2) begin
                    state_nxt = REQ2;
                    cnt_nxt   = 8'd0;
                end else if (pend == 4'd1) begin
                    state_nxt = REQ1;
                    cnt_nxt   = 8'd0;
                end
            end
            REQ2: begin
                if (hop_ack) begin
                    state_nxt = REL;
                    dec       = 2'd2;
                end else if (cnt == ACK_LIMIT) begin
                    state_nxt = FAULT;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            REQ1: begin
                if (hop_ack) begin
                    state_nxt = REL;
                    dec       = 2'd1;
                end else if (cnt == ACK_LIMIT) begin
                    state_nxt = FAULT;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            REL: begin
                if (!hop_ack) begin
                    state_nxt = IDLE;
                end
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // A coin is only requested when the balance covers it, so sum never underflows.
        accept   = chg_vld && (state != FAULT);
        sum      = {1'b0, pend} + (accept ? {2'b00, chg_amt} : 5'd0) - {3'b000, dec};
        pend_nxt = (sum > 5'd15) ? 4'hF : sum[3:0];
        ovf_nxt  = ovf | (sum > 5'd15);
    end

    assign hop2_req = (state == REQ2);
    assign hop1_req = (state == REQ1);
    assign fault    = (state == FAULT);
    assign busy     = (state != IDLE) || (pend != 4'd0);

endmodule

// File: tb/tb_fsm_change_payout.sv
// Self-checking bench for fsm_change_payout: a hopper model pops expected
// coins from a scoreboard queue filled when change strobes are driven.
module tb_fsm_change_payout;

    localparam int ACK_TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       chg_vld;
    logic [2:0] chg_amt;
    logic       hop2_req;
    logic       hop1_req;
    logic       hop_ack;
    logic [3:0] pend;
    logic       busy;
    logic       ovf;
    logic       fault;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    int exp_pend;

    fsm_change_payout #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .chg_vld  (chg_vld),
        .chg_amt  (chg_amt),
        .hop2_req (hop2_req),
        .hop1_req (hop1_req),
        .hop_ack  (hop_ack),
        .pend     (pend),
        .busy     (busy),
        .ovf      (ovf),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst     = 1'b1;
        chg_vld = 1'b0;
        chg_amt = 3'd0;
        hop_ack = 1'b0;
        exp_pend = 0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Greedy expectation: as many 2-coins as fit, then a 1-coin for an odd amount.
    task automatic push_greedy(input int amt);
        for (int v = amt; v >= 2; v -= 2) exp_q.push_back(2);
        if (amt % 2 == 1) exp_q.push_back(1);
    endtask

    task automatic strobe(input int amt);
        chg_vld = 1'b1;
        chg_amt = 3'(amt);
        @(negedge clk);
        chg_vld = 1'b0;
        chg_amt = 3'd0;
        exp_pend = (exp_pend + amt > 15) ? 15 : exp_pend + amt;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (hop2_req || hop1_req) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Hopper model: waits for a request, checks the coin, acks after `delay`
    // cycles, optionally strobing `extra` change on the ack cycle.
    task automatic serve_coin(input int delay, input int extra);
        bit ok;
        int coin;
        int exp_coin;
        wait_req(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL req_wait: got no request, expected a request within 64 cycles");
            return;
        end
        n_checks++;
        if (hop2_req && hop1_req) begin
            n_fail++;
            $display("FAIL one_req: got hop2_req=1 hop1_req=1, expected only one high");
        end
        coin = hop2_req ? 2 : 1;
        exp_coin = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
        n_checks++;
        if (coin !== exp_coin) begin
            n_fail++;
            $display("FAIL coin_value: got %0d, expected %0d", coin, exp_coin);
        end
        repeat (delay) @(negedge clk);
        hop_ack = 1'b1;
        if (extra != 0) begin
            chg_vld = 1'b1;
            chg_amt = 3'(extra);
        end
        @(negedge clk);
        chg_vld = 1'b0;
        chg_amt = 3'd0;
        exp_pend = exp_pend + extra - coin;
        if (exp_pend > 15) exp_pend = 15;
        n_checks++;
        if ({hop2_req, hop1_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL req_drop: got reqs=%b, expected 00", {hop2_req, hop1_req});
        end
        n_checks++;
        if (pend !== 4'(exp_pend)) begin
            n_fail++;
            $display("FAIL pend_after_ack: got %0d, expected %0d", pend, exp_pend);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_in_rel: got %b, expected 1", busy);
        end
        hop_ack = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({hop2_req, hop1_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_after_rel: got reqs=%b, expected 00", {hop2_req, hop1_req});
        end
    endtask

    task automatic check_drained(input logic exp_ovf);
        n_checks++;
        if (pend !== 4'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drained: got pend=%0d busy=%b, expected pend=0 busy=0", pend, busy);
        end
        n_checks++;
        if (ovf !== exp_ovf) begin
            n_fail++;
            $display("FAIL ovf_final: got %b, expected %b", ovf, exp_ovf);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_empty: got %0d coins left, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        chg_vld = 1'b0;
        chg_amt = 3'd0;
        hop_ack = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({hop2_req, hop1_req, busy, ovf, fault} !== 5'b0 || pend !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_values: got reqs=%b%b busy=%b ovf=%b fault=%b pend=%0d, expected all 0",
                     hop2_req, hop1_req, busy, ovf, fault, pend);
        end
        do_reset();
        n_checks++;
        if ({hop2_req, hop1_req, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL post_reset_idle: got reqs=%b%b busy=%b, expected 000", hop2_req, hop1_req, busy);
        end
    endtask

    task automatic test_basic();
        do_reset();
        push_greedy(3);
        strobe(3);
        n_checks++;
        if (pend !== 4'd3 || hop2_req !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_accept: got pend=%0d hop2_req=%b, expected pend=3 hop2_req=0", pend, hop2_req);
        end
        @(negedge clk);
        n_checks++;
        if (hop2_req !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_req_latency: got hop2_req=%b, expected 1", hop2_req);
        end
        serve_coin(2, 0);
        serve_coin(0, 0);
        check_drained(1'b0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        strobe(4);
        strobe(5);
        push_greedy(9);
        n_checks++;
        if (pend !== 4'd9 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_pend: got pend=%0d ovf=%b, expected pend=9 ovf=0", pend, ovf);
        end
        for (int i = 0; i < 5; i++) serve_coin(i % 3, 0);
        check_drained(1'b0);
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 4; i++) strobe(5);
        push_greedy(15);
        n_checks++;
        if (pend !== 4'd15 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_pend: got pend=%0d ovf=%b, expected pend=15 ovf=1", pend, ovf);
        end
        for (int i = 0; i < 8; i++) serve_coin(1, 0);
        check_drained(1'b1);
    endtask

    // Runs straight after test_saturate so ovf is still set going in.
    task automatic test_rst_mid();
        bit ok;
        strobe(5);
        wait_req(ok);
        n_checks++;
        if (!ok || hop2_req !== 1'b1 || pend !== 4'd5) begin
            n_fail++;
            $display("FAIL rst_setup: got hop2_req=%b pend=%0d, expected 1 and 5", hop2_req, pend);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({hop2_req, hop1_req, busy, ovf, fault} !== 5'b0 || pend !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_async: got reqs=%b%b busy=%b ovf=%b fault=%b pend=%0d, expected all 0",
                     hop2_req, hop1_req, busy, ovf, fault, pend);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_pend = 0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({hop2_req, hop1_req, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_idle: got reqs=%b%b busy=%b, expected 000", hop2_req, hop1_req, busy);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        push_greedy(2);
        strobe(2);
        push_greedy(2);
        serve_coin(0, 2);
        serve_coin(0, 0);
        check_drained(1'b0);
    endtask

    task automatic test_ack_at_limit();
        do_reset();
        push_greedy(2);
        strobe(2);
        serve_coin(ACK_TIMEOUT - 1, 0);
        n_checks++;
        if (fault !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_at_limit: got fault=%b, expected 0", fault);
        end
        check_drained(1'b0);
    endtask

    task automatic test_timeout();
        bit ok;
        int high_cycles;
        do_reset();
        strobe(2);
        wait_req(ok);
        high_cycles = 0;
        while (hop2_req && high_cycles < 40) begin
            high_cycles++;
            @(negedge clk);
        end
        n_checks++;
        if (!ok || high_cycles != ACK_TIMEOUT) begin
            n_fail++;
            $display("FAIL timeout_len: got %0d cycles, expected %0d", high_cycles, ACK_TIMEOUT);
        end
        n_checks++;
        if (fault !== 1'b1 || pend !== 4'd2 || busy !== 1'b1 || hop2_req !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_state: got fault=%b pend=%0d busy=%b hop2_req=%b, expected 1 2 1 0",
                     fault, pend, busy, hop2_req);
        end
        chg_vld = 1'b1;
        chg_amt = 3'd3;
        hop_ack = 1'b1;
        @(negedge clk);
        chg_vld = 1'b0;
        chg_amt = 3'd0;
        hop_ack = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (pend !== 4'd2 || fault !== 1'b1 || {hop2_req, hop1_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL fault_frozen: got pend=%0d fault=%b reqs=%b%b, expected 2 1 00",
                     pend, fault, hop2_req, hop1_req);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_saturate();
        test_rst_mid();
        test_same_cycle();
        test_ack_at_limit();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
